// File: rtl/mem_loader_arb.sv
// mem_loader_arb: arbitrates a single data-memory port between a streaming
// loader, a streaming readback engine and a CPU core.
//   IDLE     : CPU held in reset, memory port idle at BASE_ADDR.
//   LOAD     : ld_valid/ld_data stream written to consecutive words.
//   READBACK : consecutive words presented on rb_valid/rb_data.
//   RUN      : CPU released and its data port passed straight to memory.
// Ports:
//   clk, reset (async, active-high)
//   ld_start, rb_start, run_start, halt : one-cycle control pulses
//   len                                 : burst length in words
//   ld_valid, ld_data, ld_ready         : load stream
//   rb_valid, rb_data, rb_ready         : readback stream
//   cpu_we, cpu_addr, cpu_wdata         : CPU data-memory port
//   cpu_reset                           : reset to the CPU core
//   mem_we, mem_addr, mem_wdata, mem_rdata : arbitrated memory port
//   busy, done, err                     : status (done/err sticky)
module mem_loader_arb #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ld_start,
  input  logic                         rb_start,
  input  logic                         run_start,
  input  logic                         halt,
  input  logic [$clog2(DEPTH+1)-1:0]   len,
  input  logic                         ld_valid,
  input  logic [DATA_W-1:0]            ld_data,
  output logic                         ld_ready,
  output logic                         rb_valid,
  output logic [DATA_W-1:0]            rb_data,
  input  logic                         rb_ready,
  input  logic                         cpu_we,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic                         cpu_reset,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned LEN_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READBACK,
    ST_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ld_ready_q, rb_valid_q, busy_q, cpu_reset_q;

  logic              len_ok_c;
  logic              last_c;
  logic [ADDR_W-1:0] word_addr_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  // Burst helpers: length legality, final-word detect, current word address.
  assign len_ok_c    = (len != '0) && (len <= LEN_W'(DEPTH));
  assign last_c      = (idx_q == (len_q - LEN_W'(1)));
  assign word_addr_c = BASE_ADDR + (ADDR_W'(idx_q) << 2);

  // State and burst bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ld_ready_q  <= 1'b0;
      rb_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      done_q      <= done_d;
      err_q       <= err_d;
      // Mode flags are registered from the next state so they line up with state_q.
      ld_ready_q  <= (state_d == ST_LOAD);
      rb_valid_q  <= (state_d == ST_READBACK);
      busy_q      <= (state_d == ST_LOAD) || (state_d == ST_READBACK);
      cpu_reset_q <= (state_d != ST_RUN);
    end
  end

  // Next-state, burst bookkeeping and memory-port mux.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    done_d      = done_q;
    err_d       = err_q;
    mem_we_c    = 1'b0;
    mem_addr_c  = BASE_ADDR;
    mem_wdata_c = '0;

    case (state_q)
      ST_IDLE: begin
        // ld_start outranks rb_start outranks run_start.
        if (ld_start || rb_start) begin
          if (len_ok_c) begin
            len_d   = len;
            idx_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            state_d = ld_start ? ST_LOAD : ST_READBACK;
          end else begin
            err_d = 1'b1;
          end
        end else if (run_start) begin
          state_d = ST_RUN;
        end
      end

      ST_LOAD: begin
        mem_addr_c  = word_addr_c;
        mem_wdata_c = ld_data;
        mem_we_c    = ld_valid;
        if (ld_valid) begin
          if (last_c) begin
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end

      ST_READBACK: begin
        mem_addr_c = word_addr_c;
        if (rb_ready) begin
          if (last_c) begin
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end

      ST_RUN: begin
        // CPU owns the port combinationally while running.
        mem_we_c    = cpu_we;
        mem_addr_c  = cpu_addr;
        mem_wdata_c = cpu_wdata;
        if (halt) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ld_ready  = ld_ready_q;
  assign rb_valid  = rb_valid_q;
  // Address is frozen while stalled, so read data holds as long as memory does.
  assign rb_data   = mem_rdata;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_we    = mem_we_c;
  assign mem_addr  = mem_addr_c;
  assign mem_wdata = mem_wdata_c;

endmodule

// File: tb/tb_mem_loader_arb.sv
// Bench for mem_loader_arb: a behavioural word memory, a reference copy of the
// expected memory contents, and a scoreboard of expected writes and readback
// words that a negedge monitor consumes.
module tb_mem_loader_arb;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned LEN_W  = $clog2(DEPTH + 1);
  localparam logic [31:0] BASE   = 32'h0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic              clk;
  logic              reset;
  logic              ld_start, rb_start, run_start, halt;
  logic [LEN_W-1:0]  len;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              rb_valid;
  logic [DATA_W-1:0] rb_data;
  logic              rb_ready;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_reset;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy, done, err;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  wr_t         exp_wr [$];
  logic [31:0] exp_rb [$];
  wr_t         mon_w;
  int          n_checks = 0;
  int          n_fail   = 0;

  mem_loader_arb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset),
    .ld_start(ld_start), .rb_start(rb_start), .run_start(run_start), .halt(halt),
    .len(len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .rb_valid(rb_valid), .rb_data(rb_data), .rb_ready(rb_ready),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_reset(cpu_reset),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[9:2]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_addr(input int i);
    return BASE + 32'(4 * i);
  endfunction

  // Scoreboard monitor: every memory write and every presented readback word.
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_write_we", 64'(mem_we), 64'd0);
      end else begin
        mon_w = exp_wr.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(mon_w.addr));
        check("wr_data", 64'(mem_wdata), 64'(mon_w.data));
      end
    end
    if (rb_valid) begin
      if (exp_rb.size() == 0) begin
        check("unexpected_rb_valid", 64'(rb_valid), 64'd0);
      end else begin
        check("rb_data", 64'(rb_data), 64'(exp_rb[0]));
        if (rb_ready) void'(exp_rb.pop_front());
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
    check({tag, "_mem_we"},    64'(mem_we),    64'd0);
    check({tag, "_mem_addr"},  64'(mem_addr),  64'(BASE));
    check({tag, "_ld_ready"},  64'(ld_ready),  64'd0);
    check({tag, "_rb_valid"},  64'(rb_valid),  64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_done"},      64'(done),      64'd0);
    check({tag, "_err"},       64'(err),       64'd0);
  endtask

  task automatic clear_pulses();
    ld_start  = 1'b0;
    rb_start  = 1'b0;
    run_start = 1'b0;
    halt      = 1'b0;
  endtask

  // Load burst of n words; directed mode streams 0xA0.. with one gap after word 1.
  task automatic do_load(input int n, input bit directed);
    int sent;
    int cyc;
    logic v;
    logic [31:0] d;
    wr_t w;
    len = LEN_W'(n);
    ld_start = 1'b1;
    tick();
    clear_pulses();
    check("load_busy",      64'(busy),      64'd1);
    check("load_ld_ready",  64'(ld_ready),  64'd1);
    check("load_cpu_reset", 64'(cpu_reset), 64'd1);
    check("load_done_clr",  64'(done),      64'd0);
    check("load_err_clr",   64'(err),       64'd0);
    sent = 0;
    cyc  = 0;
    while (sent < n && cyc < 8 * n + 16) begin
      v = directed ? (cyc != 2) : ($urandom_range(0, 3) != 0);
      if (!directed) begin
        halt      = 1'($urandom_range(0, 1));
        rb_start  = 1'($urandom_range(0, 1));
        run_start = 1'($urandom_range(0, 1));
      end
      ld_valid = v;
      if (v) begin
        d = directed ? (32'hA0 + 32'(sent)) : $urandom;
        w.addr = word_addr(sent);
        w.data = d;
        exp_wr.push_back(w);
        ref_mem[w.addr[9:2]] = d;
        sent++;
      end else begin
        d = $urandom;
      end
      ld_data = d;
      tick();
      cyc++;
    end
    clear_pulses();
    ld_valid = 1'b0;
    if (sent != n) check("load_budget", 64'(sent), 64'(n));
    check("load_end_done",     64'(done),     64'd1);
    check("load_end_busy",     64'(busy),     64'd0);
    check("load_end_ld_ready", 64'(ld_ready), 64'd0);
  endtask

  // Readback burst of n words; directed mode uses rb_ready pattern 1,0,1,1,1.
  task automatic do_readback(input int n, input bit directed);
    bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int got;
    int cyc;
    logic r;
    logic [31:0] a;
    len = LEN_W'(n);
    rb_start = 1'b1;
    tick();
    clear_pulses();
    check("rb_busy",      64'(busy),      64'd1);
    check("rb_valid_on",  64'(rb_valid),  64'd1);
    check("rb_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rb_mem_we",    64'(mem_we),    64'd0);
    for (int i = 0; i < n; i++) begin
      a = word_addr(i);
      exp_rb.push_back(ref_mem[a[9:2]]);
    end
    got = 0;
    cyc = 0;
    while (got < n && cyc < 8 * n + 16) begin
      if (directed) r = (cyc < 5) ? pat[cyc] : 1'b1;
      else begin
        r = 1'($urandom_range(0, 1));
        halt      = 1'($urandom_range(0, 1));
        ld_start  = 1'($urandom_range(0, 1));
        run_start = 1'($urandom_range(0, 1));
      end
      rb_ready = r;
      if (r) got++;
      tick();
      cyc++;
    end
    clear_pulses();
    rb_ready = 1'b0;
    if (got != n) check("rb_budget", 64'(got), 64'(n));
    check("rb_end_done",  64'(done),     64'd1);
    check("rb_end_busy",  64'(busy),     64'd0);
    check("rb_end_valid", 64'(rb_valid), 64'd0);
  endtask

  task automatic run_test();
    wr_t w;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    check("run_cpu_reset", 64'(cpu_reset), 64'd0);
    check("run_busy",      64'(busy),      64'd0);
    for (int k = 0; k < 8; k++) begin
      cpu_we    = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      cpu_addr  = (k == 0) ? 32'h10 : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      cpu_wdata = (k == 0) ? 32'h55 : $urandom;
      if (k == 3) begin
        len = LEN_W'(2);
        ld_start = 1'b1;
        rb_start = 1'b1;
      end
      if (cpu_we) begin
        w.addr = cpu_addr;
        w.data = cpu_wdata;
        exp_wr.push_back(w);
        ref_mem[cpu_addr[9:2]] = cpu_wdata;
      end
      #1;
      check("run_addr_pass",  64'(mem_addr),  64'(cpu_addr));
      check("run_we_pass",    64'(mem_we),    64'(cpu_we));
      check("run_wdata_pass", 64'(mem_wdata), 64'(cpu_wdata));
      tick();
      clear_pulses();
      check("run_stay_cpu_reset", 64'(cpu_reset), 64'd0);
      check("run_stay_busy",      64'(busy),      64'd0);
    end
    cpu_we = 1'b0;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt_cpu_reset", 64'(cpu_reset), 64'd1);
    // CPU writes after halt must not reach memory.
    cpu_we    = 1'b1;
    cpu_addr  = 32'h10;
    cpu_wdata = 32'h77;
    #1;
    check("halted_mem_we",   64'(mem_we),   64'd0);
    check("halted_mem_addr", 64'(mem_addr), 64'(BASE));
    tick();
    tick();
    cpu_we = 1'b0;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("idle_halt_cpu_reset", 64'(cpu_reset), 64'd1);
    check("idle_halt_busy",      64'(busy),      64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t w;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    reset = 1'b1;
    clear_pulses();
    len = '0;
    ld_valid = 1'b0;
    ld_data  = '0;
    rb_ready = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    tick();
    tick();
    check_reset_vals("por");
    reset = 1'b0;
    tick();
    check_reset_vals("idle");

    // Directed load and readback with stalls.
    do_load(4, 1'b1);
    do_readback(4, 1'b1);

    // Illegal lengths: err sticky, done untouched, no state change.
    len = LEN_W'(0);
    ld_start = 1'b1;
    tick();
    clear_pulses();
    check("badlen0_err",  64'(err),  64'd1);
    check("badlen0_done", 64'(done), 64'd1);
    check("badlen0_busy", 64'(busy), 64'd0);
    len = LEN_W'(DEPTH + 1);
    rb_start  = 1'b1;
    run_start = 1'b1;
    tick();
    clear_pulses();
    check("badlenmax_err",       64'(err),       64'd1);
    check("badlenmax_busy",      64'(busy),      64'd0);
    check("badlenmax_rb_valid",  64'(rb_valid),  64'd0);
    check("badlenmax_cpu_reset", 64'(cpu_reset), 64'd1);

    run_test();

    // Coincident starts: load wins over readback and run, readback over run.
    rb_start  = 1'b1;
    run_start = 1'b1;
    do_load(2, 1'b0);
    run_start = 1'b1;
    do_readback(2, 1'b0);

    // Random bursts, including both length boundaries.
    for (int it = 0; it < 8; it++) begin
      do_load((it == 0) ? DEPTH : (it == 1) ? 1 : $urandom_range(1, DEPTH), 1'b0);
      do_readback((it == 2) ? DEPTH : $urandom_range(1, DEPTH), 1'b0);
    end

    // Async reset clears sticky err and done between edges.
    len = LEN_W'(0);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("pre_reset_err", 64'(err), 64'd1);
    #2 reset = 1'b1;
    #1 check_reset_vals("async_idle");
    tick();
    reset = 1'b0;
    tick();

    // Async reset in the middle of a load after two words.
    len = LEN_W'(4);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data  = $urandom;
      w.addr = word_addr(i);
      w.data = ld_data;
      exp_wr.push_back(w);
      ref_mem[w.addr[9:2]] = ld_data;
      tick();
    end
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD_BEEF;
    #2 reset = 1'b1;
    #1 check_reset_vals("async_load");
    ld_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check_reset_vals("post_reset");
    do_readback(4, 1'b0);

    tick();
    tick();
    check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    check("rb_queue_empty", 64'(exp_rb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
